decoder_proj_formal: RTL and testbench

- Formal/cover harness around a small configurable decoder driven by a 7-bit input bus.
- Decodes a 4-bit value into one of three output codes and registers the result.
- Runs an embedded reference model and raises a sticky failure flag on any mismatch.
- Exports combinational cover flags so the formal flow and simulation benches can observe reachability directly.

---
 rtl/decoder_proj_formal.sv | 158 +++++++++++++++
 tb/tb_decoder_proj_formal.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/decoder_proj_formal.sv
// Registered 16-bit decoder (one-hot / 7-segment / thermometer) with an embedded
// reference model, sticky check flag and combinational cover outputs.
module decoder_proj_formal (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  io_in,
  output logic [15:0] dec_out,
  output logic        dec_valid,
  output logic        illegal,
  output logic        chk_fail,
  output logic [3:0]  cov
);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_SEG7   = 2'b01,
    MODE_THERM  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Reference 7-segment table (gfedcba), kept apart from the decoder's case statement
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        en;
  mode_e       mode;
  logic [3:0]  value;

  logic [15:0] dec_d;
  logic        valid_d;
  logic        illegal_d;
  logic [6:0]  seg_pat;

  logic [6:0]  io_q;
  logic        prev_ok;
  mode_e       mode_q;
  logic [15:0] exp_out;
  logic        exp_valid;
  logic        exp_illegal;
  logic [4:0]  ones;
  logic        mismatch;

  assign en    = io_in[6];
  assign mode  = mode_e'(io_in[5:4]);
  assign value = io_in[3:0];

  assign cov[0] = en && (mode == MODE_ONEHOT) && (value == 4'h0);
  assign cov[1] = en && (mode == MODE_SEG7)   && (value == 4'hF);
  assign cov[2] = en && (mode == MODE_THERM)  && (value == 4'hF);
  assign cov[3] = en && (mode == MODE_RSVD);

  always_comb begin
    seg_pat = '0;
    case (value)
      4'h0: seg_pat = 7'h3F;
      4'h1: seg_pat = 7'h06;
      4'h2: seg_pat = 7'h5B;
      4'h3: seg_pat = 7'h4F;
      4'h4: seg_pat = 7'h66;
      4'h5: seg_pat = 7'h6D;
      4'h6: seg_pat = 7'h7D;
      4'h7: seg_pat = 7'h07;
      4'h8: seg_pat = 7'h7F;
      4'h9: seg_pat = 7'h6F;
      4'hA: seg_pat = 7'h77;
      4'hB: seg_pat = 7'h7C;
      4'hC: seg_pat = 7'h39;
      4'hD: seg_pat = 7'h5E;
      4'hE: seg_pat = 7'h79;
      4'hF: seg_pat = 7'h71;
      default: seg_pat = '0;
    endcase
  end

  always_comb begin
    dec_d     = '0;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    if (en) begin
      case (mode)
        MODE_ONEHOT: begin
          dec_d   = 16'h0001 << value;
          valid_d = 1'b1;
        end
        MODE_SEG7: begin
          dec_d   = {9'b0, seg_pat};
          valid_d = 1'b1;
        end
        MODE_THERM: begin
          dec_d   = ~(16'hFFFE << value);
          valid_d = 1'b1;
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  // Model works from the previous-cycle input so it lines up with the registered outputs
  assign mode_q = mode_e'(io_q[5:4]);

  always_comb begin
    exp_out     = '0;
    exp_valid   = 1'b0;
    exp_illegal = 1'b0;
    if (io_q[6]) begin
      case (mode_q)
        MODE_ONEHOT: begin
          for (int unsigned i = 0; i < 16; i++) begin
            if (4'(i) == io_q[3:0]) exp_out[i] = 1'b1;
          end
          exp_valid = 1'b1;
        end
        MODE_SEG7: begin
          exp_out   = {9'b0, SEG_TAB[io_q[3:0]]};
          exp_valid = 1'b1;
        end
        MODE_THERM: begin
          exp_out   = 16'((17'd2 << io_q[3:0]) - 17'd1);
          exp_valid = 1'b1;
        end
        default: exp_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      ones = ones + 5'(dec_out[i]);
    end
  end

  assign mismatch = (dec_out != exp_out) || (dec_valid != exp_valid) ||
                    (illegal != exp_illegal) ||
                    (dec_valid && (mode_q == MODE_ONEHOT) && (ones != 5'd1)) ||
                    (illegal && dec_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_out   <= '0;
      dec_valid <= 1'b0;
      illegal   <= 1'b0;
      io_q      <= '0;
      prev_ok   <= 1'b0;
      chk_fail  <= 1'b0;
    end else begin
      dec_out   <= dec_d;
      dec_valid <= valid_d;
      illegal   <= illegal_d;
      io_q      <= io_in;
      prev_ok   <= 1'b1;
      if (prev_ok && mismatch) chk_fail <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_proj_formal.sv
// Directed bench for decoder_proj_formal: hand-computed vectors, then a full
// 128-value sweep against a small bench model with a mid-run reset pulse.
module tb_decoder_proj_formal;

  logic        clk;
  logic        rst_n;
  logic [6:0]  io_in;
  logic [15:0] dec_out;
  logic        dec_valid;
  logic        illegal;
  logic        chk_fail;
  logic [3:0]  cov;

  int unsigned n_vec;
  int unsigned n_err;

  decoder_proj_formal dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .io_in     (io_in),
    .dec_out   (dec_out),
    .dec_valid (dec_valid),
    .illegal   (illegal),
    .chk_fail  (chk_fail),
    .cov       (cov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [6:0] v);
    io_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [15:0] e_out, input logic e_val,
                          input logic e_ill);
    chk({tag, ".dec_out"}, dec_out, e_out);
    chk({tag, ".dec_valid"}, 16'(dec_valid), 16'(e_val));
    chk({tag, ".illegal"}, 16'(illegal), 16'(e_ill));
    chk({tag, ".chk_fail"}, 16'(chk_fail), 16'h0);
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  initial begin
    logic [6:0]  v;
    logic [15:0] e_out;
    logic        e_val;
    logic        e_ill;
    logic [3:0]  e_cov;
    n_vec = 0;
    n_err = 0;

    rst_n = 1'b0;
    io_in = 7'b1000000;
    #1;
    chk("pwr.cov", 16'(cov), 16'h0001);
    @(posedge clk);
    #1;
    chk_regs("rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(7'b1000101); chk_regs("oh5", 16'h0020, 1'b1, 1'b0);
    step(7'b1000000); chk_regs("oh0", 16'h0001, 1'b1, 1'b0);
    step(7'b1001111); chk_regs("ohF", 16'h8000, 1'b1, 1'b0);
    step(7'b1011010); chk_regs("segA", 16'h0077, 1'b1, 1'b0);
    step(7'b1010000); chk_regs("seg0", 16'h003F, 1'b1, 1'b0);
    step(7'b1011000); chk_regs("seg8", 16'h007F, 1'b1, 1'b0);
    step(7'b1011111); chk_regs("segF", 16'h0071, 1'b1, 1'b0);
    chk("segF.cov", 16'(cov), 16'h0002);
    step(7'b1100011); chk_regs("th3", 16'h000F, 1'b1, 1'b0);
    step(7'b1100000); chk_regs("th0", 16'h0001, 1'b1, 1'b0);
    step(7'b1101111); chk_regs("thF", 16'hFFFF, 1'b1, 1'b0);
    chk("thF.cov", 16'(cov), 16'h0004);
    step(7'b1110000); chk_regs("rsvd", 16'h0000, 1'b0, 1'b1);
    chk("rsvd.cov", 16'(cov), 16'h0008);
    step(7'b0101010); chk_regs("dis", 16'h0000, 1'b0, 1'b0);
    chk("dis.cov", 16'(cov), 16'h0000);

    for (int k = 0; k < 128; k++) begin
      v = 7'((k * 37 + 11) % 128);
      e_out = '0;
      e_val = 1'b0;
      e_ill = 1'b0;
      if (v[6]) begin
        case (v[5:4])
          2'b00: begin e_out = 16'(2 ** int'(v[3:0])); e_val = 1'b1; end
          2'b01: begin e_out = {9'b0, seg_ref(v[3:0])}; e_val = 1'b1; end
          2'b10: begin e_out = 16'((32'd1 << (int'(v[3:0]) + 1)) - 32'd1); e_val = 1'b1; end
          default: e_ill = 1'b1;
        endcase
      end
      e_cov = {v[6] && v[5:4] == 2'b11,
               v == 7'b1101111,
               v == 7'b1011111,
               v == 7'b1000000};
      step(v);
      chk_regs($sformatf("sw%02h", v), e_out, e_val, e_ill);
      chk($sformatf("sw%02h.cov", v), 16'(cov), 16'(e_cov));
      if (k == 64) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs("midrst", 16'h0000, 1'b0, 1'b0);
        chk("midrst.cov", 16'(cov), 16'(e_cov));
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    step(7'b0000000);
    chk("final.chk_fail", 16'(chk_fail), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
